// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART instruction loader.
package uart_loader_pkg;

   // Receiver FSM states
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

   localparam int BYTES_PER_WORD = 4;
   localparam int DATA_BITS      = 8;
   localparam int IDX_W          = $clog2(BYTES_PER_WORD);
   localparam int BIT_W          = $clog2(DATA_BITS);

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART byte receiver: synchronizer, start-bit glitch reject, centre
// sampling, and single-cycle byte_valid / frame_err strobes raised in the
// cycle the stop bit is sampled.
module uart_rx
   import uart_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rxd,
   output logic [DATA_BITS-1:0] rx_byte,
   output logic                 byte_valid,
   output logic                 frame_err,
   output logic                 rx_idle
);

   localparam int HALF  = CLKS_PER_BIT / 2;
   localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

   logic             sync_p0, sync_p1, line_p2;
   logic             fall, half_tick, bit_tick;
   logic [CNT_W-1:0] cyc_cnt;
   logic [BIT_W-1:0] bit_idx;
   rx_state_t        state, state_nxt;

   // Two-flop synchronizer plus one more stage to detect the falling edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_p0 <= 1'b1;
         sync_p1 <= 1'b1;
         line_p2 <= 1'b1;
      end else begin
         sync_p0 <= rxd;
         sync_p1 <= sync_p0;
         line_p2 <= sync_p1;
      end
   end

   assign fall      = line_p2 & ~sync_p1;
   assign half_tick = (cyc_cnt == CNT_W'(HALF - 1));
   assign bit_tick  = (cyc_cnt == CNT_W'(CLKS_PER_BIT - 1));
   assign rx_idle   = (state == IDLE);

   // State, bit-time counter and bit index; counter restarts on every state change
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cyc_cnt <= '0;
         bit_idx <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE || state_nxt != state || bit_tick)
            cyc_cnt <= '0;
         else
            cyc_cnt <= cyc_cnt + 1'b1;
         if (state == IDLE)
            bit_idx <= '0;
         else if (state == DATA && bit_tick)
            bit_idx <= bit_idx + 1'b1;
      end
   end

   // Next state and stop-bit strobes
   always_comb begin
      state_nxt  = state;
      byte_valid = 1'b0;
      frame_err  = 1'b0;
      case (state)
         IDLE:  if (fall) state_nxt = START;
         START: if (half_tick) state_nxt = sync_p1 ? IDLE : DATA;
         DATA:  if (bit_tick && bit_idx == BIT_W'(DATA_BITS - 1)) state_nxt = STOP;
         STOP: begin
            if (bit_tick) begin
               state_nxt  = IDLE;
               byte_valid = sync_p1;
               frame_err  = ~sync_p1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Data shift register, LSB arrives first
   always_ff @(posedge clk) begin
      if (state == DATA && bit_tick)
         rx_byte <= {sync_p1, rx_byte[DATA_BITS-1:1]};
   end

endmodule

// File: rtl/uart_ins_loader.sv
// UART instruction loader: packs four received bytes (first byte in the
// most significant position) into a 32-bit instruction and strobes WE.
// Optional partial-word timeout enabled by defining UART_LOADER_TIMEOUT_EN.
module uart_ins_loader
   import uart_loader_pkg::*;
#(
   parameter int CLK_FREQ     = 50000000,
   parameter int BAUD         = 115200,
   parameter int TIMEOUT_BITS = 32
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        RXD,
   output logic        WE,
   output logic [31:0] W_Ins,
   output logic [7:0]  WCNT,
   output logic        BUSY,
   output logic        ERR
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int STAGE_W      = (BYTES_PER_WORD - 1) * DATA_BITS;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

   logic [DATA_BITS-1:0] rx_byte;
   logic                 byte_valid, frame_err, rx_idle;
   logic [IDX_W-1:0]     byte_idx;
   logic [STAGE_W-1:0]   stage;
   logic                 to_clr;

   uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk        (CLK),
      .rst        (RST),
      .rxd        (RXD),
      .rx_byte    (rx_byte),
      .byte_valid (byte_valid),
      .frame_err  (frame_err),
      .rx_idle    (rx_idle)
   );

   assign BUSY = !rx_idle || (byte_idx != '0);

   // Word assembly control: byte index, output word, write strobe, count, sticky error
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         byte_idx <= '0;
         WE       <= 1'b0;
         W_Ins    <= '0;
         WCNT     <= '0;
         ERR      <= 1'b0;
      end else begin
         WE <= 1'b0;
         if (frame_err) begin
            ERR      <= 1'b1;
            byte_idx <= '0;
         end else if (byte_valid) begin
            if (byte_idx == LAST_IDX) begin
               W_Ins    <= {stage, rx_byte};
               WE       <= 1'b1;
               WCNT     <= WCNT + 1'b1;
               byte_idx <= '0;
            end else begin
               byte_idx <= byte_idx + 1'b1;
            end
         end else if (to_clr) begin
            byte_idx <= '0;
         end
      end
   end

   // Staging for the leading bytes; stale contents are shifted out by the next word
   always_ff @(posedge CLK) begin
      if (byte_valid && byte_idx != LAST_IDX)
         stage <= {stage[STAGE_W-DATA_BITS-1:0], rx_byte};
   end

`ifdef UART_LOADER_TIMEOUT_EN
   localparam int TO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int TO_W   = $clog2(TO_CYC + 1);

   logic [TO_W-1:0] to_cnt;

   assign to_clr = rx_idle && (byte_idx != '0) && (to_cnt == TO_W'(TO_CYC - 1));

   // Counts idle cycles while a partial word is pending
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         to_cnt <= '0;
      else if (rx_idle && byte_idx != '0 && !to_clr)
         to_cnt <= to_cnt + 1'b1;
      else
         to_cnt <= '0;
   end
`else
   // Timeout length only matters when the timeout logic is built in
   localparam int unused_timeout_bits = TIMEOUT_BITS;
   assign to_clr = 1'b0;
`endif

endmodule

// File: tb/tb_uart_ins_loader.sv
// Directed bench for uart_ins_loader: main instance at 16 clocks/bit,
// second instance at 4 clocks/bit for the 256-word counter wrap.
module tb_uart_ins_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        rxd_a, rxd_b;
   logic        we_a, we_b;
   logic [31:0] w_ins_a, w_ins_b;
   logic [7:0]  wcnt_a, wcnt_b;
   logic        busy_a, busy_b, err_a, err_b;

   int vectors     = 0;
   int miscompares = 0;
   int we_cnt_a    = 0;
   int we_cnt_b    = 0;
   int base_a, base_b;

   always #5 clk = ~clk;

   uart_ins_loader #(.CLK_FREQ(1600), .BAUD(100), .TIMEOUT_BITS(4)) dut (
      .CLK(clk), .RST(rst), .RXD(rxd_a), .WE(we_a), .W_Ins(w_ins_a),
      .WCNT(wcnt_a), .BUSY(busy_a), .ERR(err_a)
   );

   uart_ins_loader #(.CLK_FREQ(400), .BAUD(100), .TIMEOUT_BITS(4)) dut_wrap (
      .CLK(clk), .RST(rst), .RXD(rxd_b), .WE(we_b), .W_Ins(w_ins_b),
      .WCNT(wcnt_b), .BUSY(busy_b), .ERR(err_b)
   );

   // Counts cycles with WE high; a stretched strobe shows up as an extra count
   always @(negedge clk) begin
      if (we_a) we_cnt_a++;
      if (we_b) we_cnt_b++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_a(input logic [7:0] b, input logic stop_bit);
      rxd_a = 1'b0;
      idle(16);
      for (int i = 0; i < 8; i++) begin
         rxd_a = b[i];
         idle(16);
      end
      rxd_a = stop_bit;
      idle(16);
      rxd_a = 1'b1;
   endtask

   task automatic send_b(input logic [7:0] b);
      rxd_b = 1'b0;
      idle(4);
      for (int i = 0; i < 8; i++) begin
         rxd_b = b[i];
         idle(4);
      end
      rxd_b = 1'b1;
      idle(4);
   endtask

   initial begin
      rst   = 1'b1;
      rxd_a = 1'b1;
      rxd_b = 1'b1;
      idle(3);
      check("rst_we",    32'(we_a),   32'h0);
      check("rst_wins",  w_ins_a,     32'h0);
      check("rst_wcnt",  32'(wcnt_a), 32'h0);
      check("rst_busy",  32'(busy_a), 32'h0);
      check("rst_err",   32'(err_a),  32'h0);
      rst = 1'b0;
      idle(4);

      // Word assembly
      base_a = we_cnt_a;
      send_a(8'h20, 1'b1);
      send_a(8'h08, 1'b1);
      check("busy_mid_word", 32'(busy_a), 32'h1);
      send_a(8'h00, 1'b1);
      send_a(8'h05, 1'b1);
      idle(20);
      check("word_we_cycles", 32'(we_cnt_a - base_a), 32'd1);
      check("word_wins",      w_ins_a,                32'h20080005);
      check("word_wcnt",      32'(wcnt_a),            32'd1);
      check("word_busy",      32'(busy_a),            32'h0);
      check("word_err",       32'(err_a),             32'h0);

      // Glitch on idle line
      base_a = we_cnt_a;
      rxd_a = 1'b0;
      idle(3);
      rxd_a = 1'b1;
      idle(2);
      check("glitch_busy_start", 32'(busy_a), 32'h1);
      idle(40);
      check("glitch_busy_end", 32'(busy_a),            32'h0);
      check("glitch_err",      32'(err_a),             32'h0);
      check("glitch_no_we",    32'(we_cnt_a - base_a), 32'd0);
      check("glitch_wcnt",     32'(wcnt_a),            32'd1);

      // Framing error, then recovery
      base_a = we_cnt_a;
      send_a(8'h8C, 1'b1);
      send_a(8'h55, 1'b0);
      idle(32);
      check("ferr_err", 32'(err_a), 32'h1);
      send_a(8'h11, 1'b1);
      send_a(8'h22, 1'b1);
      send_a(8'h33, 1'b1);
      idle(20);
      check("ferr_no_early_we", 32'(we_cnt_a - base_a), 32'd0);
      send_a(8'h44, 1'b1);
      idle(20);
      check("ferr_we_cycles", 32'(we_cnt_a - base_a), 32'd1);
      check("ferr_wins",      w_ins_a,                32'h11223344);
      check("ferr_wcnt",      32'(wcnt_a),            32'd2);
      check("ferr_err_sticky", 32'(err_a),            32'h1);

      // Reset mid-word
      send_a(8'h12, 1'b1);
      send_a(8'h34, 1'b1);
      idle(5);
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      idle(3);
      check("mrst_wins", w_ins_a,     32'h0);
      check("mrst_wcnt", 32'(wcnt_a), 32'd0);
      check("mrst_err",  32'(err_a),  32'h0);
      check("mrst_busy", 32'(busy_a), 32'h0);
      base_a = we_cnt_a;
      send_a(8'hDE, 1'b1);
      send_a(8'hAD, 1'b1);
      send_a(8'hBE, 1'b1);
      send_a(8'hEF, 1'b1);
      idle(20);
      check("mrst_we_cycles", 32'(we_cnt_a - base_a), 32'd1);
      check("mrst_word",      w_ins_a,                32'hDEADBEEF);
      check("mrst_word_wcnt", 32'(wcnt_a),            32'd1);

      // Lone byte, long idle, then a zero word
      base_a = we_cnt_a;
      send_a(8'hA5, 1'b1);
      idle(100);
      send_a(8'h00, 1'b1);
      send_a(8'h00, 1'b1);
      send_a(8'h00, 1'b1);
      send_a(8'h00, 1'b1);
      idle(20);
      check("tmo_we_cycles", 32'(we_cnt_a - base_a), 32'd1);
      check("tmo_wcnt",      32'(wcnt_a),            32'd2);
`ifdef UART_LOADER_TIMEOUT_EN
      check("tmo_wins",      w_ins_a,                32'h00000000);
      check("tmo_busy",      32'(busy_a),            32'h0);
`else
      check("tmo_wins",      w_ins_a,                32'hA5000000);
      check("tmo_busy",      32'(busy_a),            32'h1);
`endif

      // 256 back-to-back words on the fast instance
      base_b = we_cnt_b;
      for (int w = 0; w < 256; w++) begin
         send_b(8'(w));
         if (w == 255) check("wrap_wcnt_255", 32'(wcnt_b), 32'd255);
         send_b(~8'(w));
         send_b(8'(w) ^ 8'h5A);
         send_b(8'hC3);
      end
      idle(10);
      check("wrap_wcnt",      32'(wcnt_b),            32'd0);
      check("wrap_we_cycles", 32'(we_cnt_b - base_b), 32'd256);
      check("wrap_last_word", w_ins_b,                32'hFF00A5C3);
      check("wrap_busy",      32'(busy_b),            32'h0);
      check("wrap_err",       32'(err_b),             32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
